// File: rtl/mac_operand_splitter_pkg.sv
// Typed view of the MAC constants plus beat-count helpers for the operand splitter.
`include "mac_const.vh"

package mac_operand_splitter_pkg;

    localparam int MIN_WIDTH = `MAC_MIN_WIDTH;
    localparam int LANES     = `MAC_LANES;

    localparam logic [1:0] CFG_SINGLE = `MAC_SINGLE;
    localparam logic [1:0] CFG_DUAL   = `MAC_DUAL;
    localparam logic [1:0] CFG_QUAD   = `MAC_QUAD;

    typedef enum logic {
        ST_IDLE  = `MAC_SPLIT_IDLE,
        ST_ISSUE = `MAC_SPLIT_ISSUE
    } state_t;

    // The unused 2'b11 encoding falls back to single precision.
    function automatic logic [1:0] norm_cfg(input logic [1:0] cfg);
        return (cfg == 2'b11) ? CFG_SINGLE : cfg;
    endfunction

    function automatic logic [1:0] last_step(input logic [1:0] cfg);
        case (cfg)
            CFG_DUAL: return 2'd1;
            CFG_QUAD: return 2'd3;
            default:  return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/mac_operand_splitter_if.sv
// Operand-pair input handshake and per-lane beat output of the splitter.
interface mac_operand_splitter_if;

    logic                                                 in_valid;
    logic                                                 in_ready;
    logic [1:0]                                           in_cfg;
    logic [4*mac_operand_splitter_pkg::MIN_WIDTH-1:0]     in_a;
    logic [4*mac_operand_splitter_pkg::MIN_WIDTH-1:0]     in_b;

    logic                                                 out_valid;
    logic                                                 out_ready;
    logic [mac_operand_splitter_pkg::MIN_WIDTH-1:0]       lane_a0, lane_a1, lane_a2, lane_a3;
    logic [mac_operand_splitter_pkg::MIN_WIDTH-1:0]       lane_b0, lane_b1, lane_b2, lane_b3;
    logic [1:0]                                           out_cfg;
    logic [1:0]                                           out_step;
    logic                                                 out_last;

    modport master (
        output in_valid, in_cfg, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_cfg, out_step, out_last,
        input  lane_a0, lane_a1, lane_a2, lane_a3,
        input  lane_b0, lane_b1, lane_b2, lane_b3
    );

    modport slave (
        input  in_valid, in_cfg, in_a, in_b, out_ready,
        output in_ready, out_valid, out_cfg, out_step, out_last,
        output lane_a0, lane_a1, lane_a2, lane_a3,
        output lane_b0, lane_b1, lane_b2, lane_b3
    );

endinterface

// File: rtl/mac_const.vh
// Shared MAC-array constants: lane width, precision encodings, splitter states.
`ifndef MAC_CONST_VH
`define MAC_CONST_VH

`define MAC_MIN_WIDTH   8
`define MAC_LANES       4

`define MAC_SINGLE      2'b00
`define MAC_DUAL        2'b01
`define MAC_QUAD        2'b10

`define MAC_SPLIT_IDLE  1'b0
`define MAC_SPLIT_ISSUE 1'b1

`endif

// File: rtl/mac_split_lane_mux.sv
// Combinational slice mux: maps (cfg, step) onto the eight lane operands.
// Lane k always takes a_k; only the B slice selection depends on precision and step.
module mac_split_lane_mux
    import mac_operand_splitter_pkg::*;
(
    input  logic [1:0]             cfg,
    input  logic [1:0]             step,
    input  logic [4*MIN_WIDTH-1:0] a,
    input  logic [4*MIN_WIDTH-1:0] b,
    output logic [MIN_WIDTH-1:0]   lane_a0,
    output logic [MIN_WIDTH-1:0]   lane_a1,
    output logic [MIN_WIDTH-1:0]   lane_a2,
    output logic [MIN_WIDTH-1:0]   lane_a3,
    output logic [MIN_WIDTH-1:0]   lane_b0,
    output logic [MIN_WIDTH-1:0]   lane_b1,
    output logic [MIN_WIDTH-1:0]   lane_b2,
    output logic [MIN_WIDTH-1:0]   lane_b3
);

    logic [MIN_WIDTH-1:0] bs [LANES];

    for (genvar k = 0; k < LANES; k++) begin : g_slice
        assign bs[k] = b[k*MIN_WIDTH +: MIN_WIDTH];
    end

    assign lane_a0 = a[0*MIN_WIDTH +: MIN_WIDTH];
    assign lane_a1 = a[1*MIN_WIDTH +: MIN_WIDTH];
    assign lane_a2 = a[2*MIN_WIDTH +: MIN_WIDTH];
    assign lane_a3 = a[3*MIN_WIDTH +: MIN_WIDTH];

    always_comb begin
        lane_b0 = bs[0];
        lane_b1 = bs[1];
        lane_b2 = bs[2];
        lane_b3 = bs[3];
        case (cfg)
            CFG_DUAL: begin
                // Lower lane pair walks b_0/b_1, upper pair walks b_2/b_3.
                lane_b0 = bs[{1'b0, step[0]}];
                lane_b1 = bs[{1'b0, step[0]}];
                lane_b2 = bs[{1'b1, step[0]}];
                lane_b3 = bs[{1'b1, step[0]}];
            end
            CFG_QUAD: begin
                lane_b0 = bs[step];
                lane_b1 = bs[step];
                lane_b2 = bs[step];
                lane_b3 = bs[step];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mac_operand_splitter.sv
// Slices a wide operand pair into 1/2/4 step-tagged beats for the 4-lane MAC array.
// Latency: first beat valid the cycle after input accept; in_ready reopens on the last beat (no bubble).
// Backpressure: out_ready low freezes the current beat. MAC_SPLIT_SKIP_ZERO_EN skips all-zero non-final B beats.
module mac_operand_splitter
    import mac_operand_splitter_pkg::*;
(
    input logic                   clk,
    input logic                   rst,
    mac_operand_splitter_if.slave bus
);

    state_t                 state;
    logic [1:0]             step;
    logic [1:0]             cfg_q;
    logic [4*MIN_WIDTH-1:0] a_q;
    logic [4*MIN_WIDTH-1:0] b_q;

    logic issue;
    logic at_last;
    logic skip;
    logic out_fire;
    logic take;

    mac_split_lane_mux u_lane_mux (
        .cfg     (cfg_q),
        .step    (step),
        .a       (a_q),
        .b       (b_q),
        .lane_a0 (bus.lane_a0),
        .lane_a1 (bus.lane_a1),
        .lane_a2 (bus.lane_a2),
        .lane_a3 (bus.lane_a3),
        .lane_b0 (bus.lane_b0),
        .lane_b1 (bus.lane_b1),
        .lane_b2 (bus.lane_b2),
        .lane_b3 (bus.lane_b3)
    );

    assign issue   = (state == ST_ISSUE);
    assign at_last = (step == last_step(cfg_q));

`ifdef MAC_SPLIT_SKIP_ZERO_EN
    // The mux already selects this beat's B slices, so an all-zero lane_b means nothing to multiply.
    assign skip = issue && !at_last &&
                  ({bus.lane_b3, bus.lane_b2, bus.lane_b1, bus.lane_b0} == '0);
`else
    assign skip = 1'b0;
`endif

    assign bus.out_valid = issue && !skip;
    assign bus.out_last  = issue && at_last;
    assign bus.out_cfg   = cfg_q;
    assign bus.out_step  = step;

    assign out_fire     = bus.out_valid && bus.out_ready;
    assign bus.in_ready = !issue || (out_fire && at_last);
    assign take         = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            step  <= 2'd0;
            cfg_q <= CFG_SINGLE;
            a_q   <= '0;
            b_q   <= '0;
        end else if (take) begin
            state <= ST_ISSUE;
            step  <= 2'd0;
            cfg_q <= norm_cfg(bus.in_cfg);
            a_q   <= bus.in_a;
            b_q   <= bus.in_b;
        end else if (issue) begin
            if (skip || (out_fire && !at_last)) begin
                step <= step + 2'd1;
            end else if (out_fire) begin
                state <= ST_IDLE;
                step  <= 2'd0;
            end
        end
    end

endmodule
